seq_mult: RTL and testbench

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/seq_mult.sv | 112 +++++++++++
 tb/tb_seq_mult.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned per operation,
// with valid/ready handshakes on both the operand and the product side.
module seq_mult #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   p,
    output logic             busy
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  mcand;
    logic [N-1:0]   mplier;
    logic [PW-1:0]  acc;
    logic           neg;

    logic           accept_c;
    logic           last_c;
    logic           a_neg_c;
    logic           b_neg_c;
    logic [N-1:0]   a_mag_c;
    logic [N-1:0]   b_mag_c;
    logic [PW-1:0]  acc_sum_c;

    // Handshake/status flags decode directly from the state register
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);

    // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which still fits in N unsigned bits
    always_comb begin
        a_neg_c = sgn & a[N-1];
        b_neg_c = sgn & b[N-1];
        a_mag_c = a_neg_c ? N'(-a) : a;
        b_mag_c = b_neg_c ? N'(-b) : b;
    end

    // Per-cycle control terms and the shift-add step
    always_comb begin
        accept_c  = (state == IDLE) && in_valid;
        last_c    = (state == CALC) && (cnt == CW'(N - 1));
        acc_sum_c = acc + (mplier[0] ? mcand : '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c)  state_next = CALC;
            CALC:    if (last_c)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, one multiplier bit per CALC cycle,
    // sign-correct and publish the product on the last CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else if (accept_c) begin
            cnt    <= '0;
            mcand  <= PW'(a_mag_c);
            mplier <= b_mag_c;
            acc    <= '0;
            neg    <= a_neg_c ^ b_neg_c;
        end else if (state == CALC) begin
            cnt    <= cnt + CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_sum_c;
            if (last_c) begin
                cnt <= '0;
                p   <= neg ? PW'(-acc_sum_c) : acc_sum_c;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed corners plus randomized
// signed/unsigned operations with output stalls, against an arithmetic model.
module tb_seq_mult;

    localparam int unsigned N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sgn;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    seq_mult #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: interpret operands as integers and keep the low 2N bits
    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y,
                                                input logic s);
        longint xv;
        longint yv;
        longint prod;
        xv   = s ? longint'($signed(x)) : longint'(x);
        yv   = s ? longint'($signed(y)) : longint'(y);
        prod = xv * yv;
        return prod[2*N-1:0];
    endfunction

    // Drives one operation; called at edge+1. Returns product, latency in edges
    // after the accept edge, and whether p/out_valid stayed put during the stall.
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic is,
                          input int stall, input bit hold_valid,
                          output logic [2*N-1:0] got, output int lat, output bit stable);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        a = ia; b = ib; sgn = is; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = hold_valid;
        a = N'($urandom); b = N'($urandom); sgn = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        got = p;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!out_valid || p !== got || in_ready) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sgn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b ov=%b busy=%b p=%h, want 1 0 0 0000",
                     in_ready, out_valid, busy, p);
        end
        in_valid = 1'b1; a = 8'd5; b = 8'd5;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_priority: got busy=%b rdy=%b, want 0 1", busy, in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [N-1:0]   da[6] = '{8'd3, 8'd255, 8'hF6, 8'h80, 8'h80, 8'd0};
        logic [N-1:0]   db[6] = '{8'd7, 8'd255, 8'h05, 8'h80, 8'h7F, 8'hC3};
        logic           ds[6] = '{1'b0, 1'b0,   1'b1,  1'b1,  1'b1,  1'b1};
        logic [2*N-1:0] dp[6] = '{16'd21, 16'd65025, 16'hFFCE, 16'h4000, 16'hC080, 16'h0000};
        logic [2*N-1:0] got;
        int             lat;
        bit             stable;
        for (int i = 0; i < 6; i++) begin
            run_op(da[i], db[i], ds[i], 0, 1'b0, got, lat, stable);
            n_vec++;
            if (got !== dp[i] || lat != N) begin
                n_err++;
                $display("FAIL directed_%0d: got p=%h lat=%0d, want p=%h lat=%0d",
                         i, got, lat, dp[i], N);
            end
        end
    endtask

    task automatic test_ignore_inputs();
        logic [2*N-1:0] got;
        int             lat;
        bit             stable;
        run_op(8'd13, 8'd11, 1'b0, 2, 1'b1, got, lat, stable);
        n_vec++;
        if (got !== 16'd143 || lat != N || !stable) begin
            n_err++;
            $display("FAIL ignore_inputs: got p=%0d lat=%0d stable=%0b, want 143 %0d 1",
                     got, lat, stable, N);
        end
    endtask

    task automatic test_backpressure();
        logic [2*N-1:0] got;
        int             lat;
        bit             stable;
        int             w;
        run_op(8'd9, 8'd6, 1'b0, 5, 1'b0, got, lat, stable);
        n_vec++;
        if (got !== 16'd54 || !stable) begin
            n_err++;
            $display("FAIL backpressure_hold: got p=%0d stable=%0b, want 54 1", got, stable);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_ready: got in_ready=%b after handshake, want 1", in_ready);
        end
        a = 8'd4; b = 8'd5; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back_accept: got busy=%b, want 1", busy);
        end
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        n_vec++;
        if (p !== 16'd20 || w != N) begin
            n_err++;
            $display("FAIL back_to_back_result: got p=%0d lat=%0d, want 20 %0d", p, w, N);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic [2*N-1:0] got;
        int             lat;
        bit             stable;
        bit             saw_valid;
        a = 8'd20; b = 8'd30; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || p !== '0) begin
            n_err++;
            $display("FAIL reset_mid_calc_state: got rdy=%b busy=%b ov=%b p=%h, want 1 0 0 0000",
                     in_ready, busy, out_valid, p);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        n_vec++;
        if (saw_valid) begin
            n_err++;
            $display("FAIL reset_mid_calc_abort: got an out_valid pulse, want none");
        end
        run_op(8'd12, 8'd9, 1'b0, 0, 1'b0, got, lat, stable);
        n_vec++;
        if (got !== 16'd108 || lat != N) begin
            n_err++;
            $display("FAIL reset_mid_calc_next: got p=%0d lat=%0d, want 108 %0d", got, lat, N);
        end
    endtask

    task automatic test_reset_in_done();
        int w;
        a = 8'd7; b = 8'd7; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== '0) begin
            n_err++;
            $display("FAIL reset_in_done: got ov=%b rdy=%b p=%h, want 0 1 0000",
                     out_valid, in_ready, p);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]   ra;
        logic [N-1:0]   rb;
        logic [2*N-1:0] want;
        logic [2*N-1:0] got;
        int             lat;
        bit             stable;
        int             stall;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                ra    = N'($urandom);
                rb    = N'($urandom);
                stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                want  = ref_prod(ra, rb, 1'(m));
                run_op(ra, rb, 1'(m), stall, 1'b0, got, lat, stable);
                n_vec++;
                if (got !== want || lat != N || !stable) begin
                    n_err++;
                    $display("FAIL random_sgn%0d_%0d: a=%h b=%h got p=%h lat=%0d stable=%0b, want p=%h lat=%0d stable=1",
                             m, i, ra, rb, got, lat, stable, want, N);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_inputs();
        test_backpressure();
        test_reset_mid_calc();
        test_reset_in_done();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
